// File: rtl/inst_fetch_initiator.sv
// Instruction-bus initiator: holds the fetch PC, issues dual-word reads and
// buffers {pc, inst} pairs so the decoder can take up to two per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | issuing reads whenever at least two queue slots are free
// ST_HALT  | misaligned redirect pending; no reads until aligned redirect
module inst_fetch_initiator #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] bus_address,
    output logic        bus_read,
    input  logic        bus_stall,
    input  logic [31:0] bus_data_rd,
    input  logic [31:0] bus_data_rd_2,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        pop_1,
    input  logic        pop_2,
    output logic        inst_valid_1,
    output logic [31:0] inst_1,
    output logic [31:0] pc_1,
    output logic        inst_valid_2,
    output logic [31:0] inst_2,
    output logic [31:0] pc_2,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     fault_pc_q, fault_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_inst [DEPTH];

    logic            accept;
    logic            valid_1, valid_2;
    logic            do_pop_1, do_pop_2;
    logic [CW-1:0]   pop_cnt;
    logic [CW-1:0]   push_cnt;
    logic [PW-1:0]   rd_ptr_nx, wr_ptr_nx;

    assign rd_ptr_nx = rd_ptr_q + PW'(1);
    assign wr_ptr_nx = wr_ptr_q + PW'(1);

    assign valid_1 = (count_q >= CW'(1));
    assign valid_2 = (count_q >= CW'(2));

    // Registered count only: a pop in this cycle does not open room for a read.
    assign bus_read    = (state_q == ST_FETCH) && !rst && (count_q <= CW'(DEPTH - 2));
    assign bus_address = rst ? RESET_PC : pc_q;

    assign accept   = bus_read && !bus_stall && !redirect_valid;
    assign do_pop_1 = pop_1 && valid_1 && !redirect_valid;
    assign do_pop_2 = pop_1 && pop_2 && valid_2 && !redirect_valid;
    assign pop_cnt  = CW'(do_pop_1) + CW'(do_pop_2);
    assign push_cnt = accept ? CW'(2) : CW'(0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q + push_cnt - pop_cnt;
        rd_ptr_d   = rd_ptr_q + PW'(pop_cnt);
        wr_ptr_d   = wr_ptr_q + PW'(push_cnt);

        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = ST_HALT;
                fault_pc_d = redirect_pc;
            end else begin
                state_d = ST_FETCH;
                pc_d    = redirect_pc;
            end
        end else if (accept) begin
            pc_d = pc_q + 32'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset; the valid flags gate every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_pc[wr_ptr_q]    <= pc_q;
            mem_inst[wr_ptr_q]  <= bus_data_rd;
            mem_pc[wr_ptr_nx]   <= pc_q + 32'd4;
            mem_inst[wr_ptr_nx] <= bus_data_rd_2;
        end
    end

    assign inst_valid_1 = !rst && valid_1;
    assign inst_valid_2 = !rst && valid_2;
    assign pc_1   = inst_valid_1 ? mem_pc[rd_ptr_q]    : 32'd0;
    assign inst_1 = inst_valid_1 ? mem_inst[rd_ptr_q]  : 32'd0;
    assign pc_2   = inst_valid_2 ? mem_pc[rd_ptr_nx]   : 32'd0;
    assign inst_2 = inst_valid_2 ? mem_inst[rd_ptr_nx] : 32'd0;

    assign fetch_fault = !rst && (state_q == ST_HALT);
    assign fault_pc    = rst ? 32'd0 : fault_pc_q;

endmodule

// File: tb/tb_inst_fetch_initiator.sv
// Bench for inst_fetch_initiator: directed table, corner sequences and a
// random phase checked against a queue-based model of the fetch buffer.
module tb_inst_fetch_initiator;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_stall;
    logic [31:0] bus_data_rd;
    logic [31:0] bus_data_rd_2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pop_1;
    logic        pop_2;
    logic        inst_valid_1;
    logic [31:0] inst_1;
    logic [31:0] pc_1;
    logic        inst_valid_2;
    logic [31:0] inst_2;
    logic [31:0] pc_2;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    logic        rom_const = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    inst_fetch_initiator #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .bus_address(bus_address), .bus_read(bus_read), .bus_stall(bus_stall),
        .bus_data_rd(bus_data_rd), .bus_data_rd_2(bus_data_rd_2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pop_1(pop_1), .pop_2(pop_2),
        .inst_valid_1(inst_valid_1), .inst_1(inst_1), .pc_1(pc_1),
        .inst_valid_2(inst_valid_2), .inst_2(inst_2), .pc_2(pc_2),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    // ROM slave: constant 0x11/0x22 mode or an address-derived pattern.
    assign bus_data_rd   = rom_const ? (bus_address[2] ? 32'h22 : 32'h11)
                                     : (bus_address ^ 32'h3C3C_5A5A);
    assign bus_data_rd_2 = rom_const ? (bus_address[2] ? 32'h11 : 32'h22)
                                     : ((bus_address + 32'd4) ^ 32'h3C3C_5A5A);

    function automatic logic [31:0] word(input logic [31:0] a);
        if (rom_const) return a[2] ? 32'h22 : 32'h11;
        return a ^ 32'h3C3C_5A5A;
    endfunction

    // Reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc   = RESET_PC;
    logic        m_halt = 1'b0;
    logic [31:0] m_fpc  = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic m_read();
        return !rst && !m_halt && (mq.size() <= DEPTH - 2);
    endfunction

    task automatic model_check();
        logic v1, v2;
        v1 = !rst && (mq.size() >= 1);
        v2 = !rst && (mq.size() >= 2);
        chk("m_read", bus_read, m_read());
        chk("m_addr", bus_address, rst ? RESET_PC : m_pc);
        chk("m_v1", inst_valid_1, v1);
        chk("m_v2", inst_valid_2, v2);
        chk("m_pc1", pc_1, v1 ? mq[0].pc : 32'd0);
        chk("m_inst1", inst_1, v1 ? mq[0].inst : 32'd0);
        chk("m_pc2", pc_2, v2 ? mq[1].pc : 32'd0);
        chk("m_inst2", inst_2, v2 ? mq[1].inst : 32'd0);
        chk("m_fault", fetch_fault, !rst && m_halt);
        if (rst) chk("m_fpc_rst", fault_pc, 32'd0);
        else if (m_halt) chk("m_fpc", fault_pc, m_fpc);
    endtask

    task automatic model_update();
        logic acc;
        int   n;
        acc = m_read() && !bus_stall;
        if (rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_halt = 1'b0;
            m_fpc  = 32'd0;
        end else if (redirect_valid) begin
            mq.delete();
            if (redirect_pc[1:0] != 2'b00) begin
                m_halt = 1'b1;
                m_fpc  = redirect_pc;
            end else begin
                m_halt = 1'b0;
                m_pc   = redirect_pc;
            end
        end else begin
            n = pop_1 ? (pop_2 ? 2 : 1) : 0;
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{pc: m_pc, inst: word(m_pc)});
                mq.push_back('{pc: m_pc + 32'd4, inst: word(m_pc + 32'd4)});
                m_pc = m_pc + 32'd8;
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [31:0] a,
                         input logic q1, input logic q2);
        @(negedge clk);
        rst = r; bus_stall = s; redirect_valid = v; redirect_pc = a; pop_1 = q1; pop_2 = q2;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] rpc;
        logic        p1, p2;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_v1, e_v2;
        logic [31:0] e_pc1;
        logic        e_fault;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        //           rst stl rv rpc           p1 p2 read addr          v1 v2 pc1           flt fpc
        tbl[0]  = '{1, 0, 0, 32'h0,          0, 0, 0, 32'hBFC0_0000, 0, 0, 32'h0,          0, 32'h0};
        tbl[1]  = '{0, 1, 0, 32'h0,          0, 0, 1, 32'hBFC0_0000, 0, 0, 32'h0,          0, 32'h0};
        tbl[2]  = '{0, 1, 0, 32'h0,          0, 0, 1, 32'hBFC0_0000, 0, 0, 32'h0,          0, 32'h0};
        tbl[3]  = '{0, 1, 0, 32'h0,          0, 0, 1, 32'hBFC0_0000, 0, 0, 32'h0,          0, 32'h0};
        tbl[4]  = '{0, 0, 0, 32'h0,          0, 0, 1, 32'hBFC0_0000, 0, 0, 32'h0,          0, 32'h0};
        tbl[5]  = '{0, 0, 0, 32'h0,          1, 0, 1, 32'hBFC0_0008, 1, 1, 32'hBFC0_0000, 0, 32'h0};
        tbl[6]  = '{0, 0, 0, 32'h0,          0, 0, 1, 32'hBFC0_0010, 1, 1, 32'hBFC0_0004, 0, 32'h0};
        tbl[7]  = '{0, 0, 1, 32'h8000_0100,  0, 0, 1, 32'hBFC0_0018, 1, 1, 32'hBFC0_0004, 0, 32'h0};
        tbl[8]  = '{0, 0, 0, 32'h0,          0, 0, 1, 32'h8000_0100, 0, 0, 32'h0,          0, 32'h0};
        tbl[9]  = '{0, 0, 1, 32'h8000_0102,  0, 0, 1, 32'h8000_0108, 1, 1, 32'h8000_0100, 0, 32'h0};
        tbl[10] = '{0, 0, 0, 32'h0,          0, 0, 0, 32'h8000_0108, 0, 0, 32'h0,          1, 32'h8000_0102};
        tbl[11] = '{0, 0, 0, 32'h0,          1, 1, 0, 32'h8000_0108, 0, 0, 32'h0,          1, 32'h8000_0102};
        tbl[12] = '{0, 0, 1, 32'h8000_0200,  0, 0, 0, 32'h8000_0108, 0, 0, 32'h0,          1, 32'h8000_0102};
        tbl[13] = '{0, 0, 0, 32'h0,          0, 0, 1, 32'h8000_0200, 0, 0, 32'h0,          0, 32'h0};
        tbl[14] = '{0, 0, 0, 32'h0,          0, 1, 1, 32'h8000_0208, 1, 1, 32'h8000_0200, 0, 32'h0};
        tbl[15] = '{0, 1, 0, 32'h0,          0, 0, 1, 32'h8000_0210, 1, 1, 32'h8000_0200, 0, 32'h0};

        rst = 1'b1; bus_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        pop_1 = 1'b0; pop_2 = 1'b0;
        repeat (2) begin drive(1, 0, 0, 0, 0, 0); tick(); end

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rpc, tbl[i].p1, tbl[i].p2);
            chk($sformatf("tbl%0d_read", i), bus_read, tbl[i].e_read);
            chk($sformatf("tbl%0d_addr", i), bus_address, tbl[i].e_addr);
            chk($sformatf("tbl%0d_v1", i), inst_valid_1, tbl[i].e_v1);
            chk($sformatf("tbl%0d_v2", i), inst_valid_2, tbl[i].e_v2);
            chk($sformatf("tbl%0d_pc1", i), pc_1, tbl[i].e_pc1);
            chk($sformatf("tbl%0d_fault", i), fetch_fault, tbl[i].e_fault);
            if (tbl[i].e_fault || tbl[i].rst)
                chk($sformatf("tbl%0d_fpc", i), fault_pc, tbl[i].e_fpc);
            tick();
        end

        // Fill from reset with the constant ROM, then drain two per cycle.
        rom_const = 1'b1;
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("fill_read", bus_read, 1'b1);
            chk("fill_addr", bus_address, RESET_PC + 32'(8 * k));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("full_read", bus_read, 1'b0);
        chk("full_pc1", pc_1, 32'hBFC0_0000);
        chk("full_inst1", inst_1, 32'h11);
        chk("full_pc2", pc_2, 32'hBFC0_0004);
        chk("full_inst2", inst_2, 32'h22);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 1);
            chk("drain_pc1", pc_1, RESET_PC + 32'(8 * k));
            chk("drain_read", bus_read, k != 0);
            tick();
        end
        rom_const = 1'b0;

        // Address wrap at the top of the space.
        drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap_addr0", bus_address, 32'hFFFF_FFF8);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap_pc1", pc_1, 32'hFFFF_FFF8);
        chk("wrap_pc2", pc_2, 32'hFFFF_FFFC);
        chk("wrap_addr1", bus_address, 32'h0000_0000);
        tick();

        // Reset during a stalled request.
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0);
        chk("rststall_read", bus_read, 1'b0);
        chk("rststall_addr", bus_address, RESET_PC);
        chk("rststall_v1", inst_valid_1, 1'b0);
        tick();
        drive(0, 1, 0, 0, 0, 0);
        chk("postrst_read", bus_read, 1'b1);
        chk("postrst_addr", bus_address, RESET_PC);
        tick();

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                1: tgt = $urandom & 32'hFFFF_FFFC;
                2: tgt = $urandom;
                default: tgt = 32'h8000_0000 + 32'($urandom_range(0, 63) * 4);
            endcase
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 29) == 0, tgt,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
